spram_fifo_ctrl: RTL
====================

// Module: spram_fifo_ctrl
// PURPOSE
//  Sequences one sync-read single-port RAM (1-cycle read latency; read and write
//  mutually exclusive per cycle) as a circular FIFO in the RX datapath, e.g. a
//  symbol buffer between the FFT stage and the demapper. It shares the single
//  RAM port between a valid/ready writer and a valid/ready reader, using
//  round-robin arbitration. It owns the pointers, occupancy and read-data valid.
// PARAMETERS
//  DATA_WIDTH  64  RAM word width
//  ADDR_WIDTH  5   RAM address width
//  RAM_DEPTH   32  number of words used; must be <= 2**ADDR_WIDTH (need not be a power of 2)
// PORTS
//  iClk        in   1            clock; all logic is on the rising edge
//  iRst_n      in   1            asynchronous, active-low reset
//  iFlush      in   1            synchronous clear of the FIFO state
//  iWr_Valid   in   1            writer has a word
//  iWr_Data    in   DATA_WIDTH   writer word
//  oWr_Ready   out  1            write accepted this cycle (combinational)
//  oRd_Valid   out  1            oRd_Data holds an unconsumed word
//  oRd_Data    out  DATA_WIDTH   read word; driven directly from iRam_Data
//  iRd_Ready   in   1            reader consumes the word when oRd_Valid=1
//  oRam_R_EN   out  1            RAM read enable (combinational)
//  oRam_W_EN   out  1            RAM write enable (combinational)
//  oRam_Addr   out  ADDR_WIDTH   RAM address: wr_ptr on a write, rd_ptr on a read, else rd_ptr
//  oRam_Data   out  DATA_WIDTH   equals iWr_Data
//  iRam_Data   in   DATA_WIDTH   RAM registered read data
//  oLevel      out  ADDR_WIDTH+1 words stored in RAM and not yet read-issued
//  oFull       out  1            oLevel == RAM_DEPTH
//  oEmpty      out  1            oLevel == 0
// BEHAVIOUR
//  - Reset (async, iRst_n=0): wr_ptr=0, rd_ptr=0, oLevel=0, oRd_Valid=0,
//    prio=WRITE, oEmpty=1, oFull=0. oRam_R_EN, oRam_W_EN and oWr_Ready are 0
//    while reset is held. RAM contents are don't-care; the RAM's own reset is
//    tied to ~iRst_n at the parent.
//  - Requests:
//      wr_req = iWr_Valid & !oFull
//      rd_req = !oEmpty & (!oRd_Valid | iRd_Ready)
//  - Grant: at most one grant per cycle.
//      Only one request active -> grant it.
//      Both active -> grant to prio, then prio flips to the other side.
//      prio changes only on contention.
//  - Write grant: oRam_W_EN=1, oWr_Ready=1; RAM[wr_ptr] <= iWr_Data;
//    wr_ptr advances.
//  - Read grant: oRam_R_EN=1; rd_ptr advances; oRd_Valid=1 on the next cycle,
//    with the word on iRam_Data. Latency is 1 cycle from grant to valid.
//  - oRd_Valid clears after a cycle with oRd_Valid & iRd_Ready and no read grant.
//    A read grant in the same cycle keeps oRd_Valid at 1, giving back-to-back
//    words. The RAM read port is not re-enabled while a word is held, so
//    oRd_Data stays stable under backpressure.
//  - Pointers wrap from RAM_DEPTH-1 to 0.
//  - oLevel: +1 on a write grant, -1 on a read grant. Both cannot occur in one
//    cycle.
//  - Full: writes stall (oWr_Ready=0). Empty: no read is issued, but a held
//    oRd_Valid word still drains.
//  - Maximum sustained throughput is 1 word/cycle total, shared between the two
//    sides. Under contention each side gets 50%.
//  - iFlush=1: no grants that cycle. Next cycle pointers, oLevel, oRd_Valid and
//    prio hold their reset values. Flush takes priority over all requests.
//  - Reset asserted mid-operation: all state clears immediately. An in-flight
//    read word is discarded.
// STRUCTURE
//  - Shared package: a PRIO_WRITE/PRIO_READ encoding, and a clog2 function for
//    the width check RAM_DEPTH <= 2**ADDR_WIDTH.
//  - One sub-module: rr_arb2 (2-requester round-robin arbiter: req[1:0] in,
//    one-hot gnt[1:0] out, registered prio). The SPRAM is instantiated by the
//    parent, not inside this block.
// TESTING
//  1 Hold iRd_Ready=0; write 32 words 0..31 -> oFull=1 after the 32nd; a 33rd
//    iWr_Valid sees oWr_Ready=0; oLevel=32.
//  2 Drain with iRd_Ready=1 -> oRd_Data reads 0..31 in order. The first valid
//    comes 1 cycle after the first oRam_R_EN; oEmpty=1 at the end.
//  3 Both sides continuously active, FIFO half-full -> grants strictly
//    alternate W,R,W,R; oLevel stays constant +/-1.
//  4 RAM_DEPTH=24: write and read 60 words -> the address sequence wraps
//    23->0 twice; data order is preserved.
//  5 oRd_Valid=1, hold iRd_Ready=0 for 5 cycles -> oRd_Data stable, no
//    oRam_R_EN; release -> the next word arrives 1 cycle later.
//  6 Drop iRst_n (or pulse iFlush) with oLevel=10 and oRd_Valid=1 ->
//    oLevel=0, oRd_Valid=0, oEmpty=1; the next write lands at address 0.

Source files
------------

// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller.
// Covers the arbitration priority encoding, the request bit positions and the width helper.
package spram_fifo_ctrl_pkg;

    typedef enum logic {
        PRIO_WRITE = 1'b0,
        PRIO_READ  = 1'b1
    } prio_t;

    localparam int unsigned REQ_WR = 0;
    localparam int unsigned REQ_RD = 1;

    // Smallest width that can hold the values 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/spram_fifo_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// The priority register flips only when both requesters are active together.
module rr_arb2
    import spram_fifo_ctrl_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iFlush,
    input  logic [1:0] iReq,
    output logic [1:0] oGnt
);

    prio_t prio;
    prio_t prioNext;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prio <= PRIO_WRITE;
        end else begin
            prio <= prioNext;
        end
    end

    always_comb begin
        oGnt     = '0;
        prioNext = prio;
        if (iFlush) begin
            prioNext = PRIO_WRITE;
        end else begin
            case (iReq)
                2'b01: oGnt = 2'b01;
                2'b10: oGnt = 2'b10;
                2'b11: begin
                    if (prio == PRIO_WRITE) begin
                        oGnt     = 2'b01;
                        prioNext = PRIO_READ;
                    end else begin
                        oGnt     = 2'b10;
                        prioNext = PRIO_WRITE;
                    end
                end
                default: oGnt = '0;
            endcase
        end
    end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// Circular FIFO sequencer for one sync-read single-port RAM.
// A valid/ready writer and a valid/ready reader share the single RAM port under round-robin arbitration.
module spram_fifo_ctrl
    import spram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int RAM_DEPTH  = 32
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iFlush,
    input  logic                  iWr_Valid,
    input  logic [DATA_WIDTH-1:0] iWr_Data,
    output logic                  oWr_Ready,
    output logic                  oRd_Valid,
    output logic [DATA_WIDTH-1:0] oRd_Data,
    input  logic                  iRd_Ready,
    output logic                  oRam_R_EN,
    output logic                  oRam_W_EN,
    output logic [ADDR_WIDTH-1:0] oRam_Addr,
    output logic [DATA_WIDTH-1:0] oRam_Data,
    input  logic [DATA_WIDTH-1:0] iRam_Data,
    output logic [ADDR_WIDTH:0]   oLevel,
    output logic                  oFull,
    output logic                  oEmpty
);

    if (int'(clog2(RAM_DEPTH)) > ADDR_WIDTH) begin : gDepthCheck
        $error("RAM_DEPTH does not fit in ADDR_WIDTH address bits");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LEVEL = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [ADDR_WIDTH:0]   level;
    logic                  rdValid;
    logic                  wrReq;
    logic                  rdReq;
    logic                  reqEnable;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  wrGnt;
    logic                  rdGnt;

    assign oFull  = (level == DEPTH_LEVEL);
    assign oEmpty = (level == '0);

    // A held word blocks further reads so oRd_Data stays stable under backpressure.
    assign wrReq     = iWr_Valid & ~oFull;
    assign rdReq     = ~oEmpty & (~rdValid | iRd_Ready);
    assign reqEnable = iRst_n & ~iFlush;

    always_comb begin
        req         = '0;
        req[REQ_WR] = wrReq & reqEnable;
        req[REQ_RD] = rdReq & reqEnable;
    end

    rr_arb2 uArb (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iFlush (iFlush),
        .iReq   (req),
        .oGnt   (gnt)
    );

    assign wrGnt = gnt[REQ_WR];
    assign rdGnt = gnt[REQ_RD];

    assign oWr_Ready = wrGnt;
    assign oRam_W_EN = wrGnt;
    assign oRam_R_EN = rdGnt;
    assign oRam_Addr = wrGnt ? wrPtr : rdPtr;
    assign oRam_Data = iWr_Data;
    assign oRd_Data  = iRam_Data;
    assign oRd_Valid = rdValid;
    assign oLevel    = level;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            level   <= '0;
            rdValid <= 1'b0;
        end else if (iFlush) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            level   <= '0;
            rdValid <= 1'b0;
        end else begin
            if (wrGnt) begin
                wrPtr <= (wrPtr == LAST_ADDR) ? '0 : wrPtr + 1'b1;
                level <= level + 1'b1;
            end
            if (rdGnt) begin
                rdPtr <= (rdPtr == LAST_ADDR) ? '0 : rdPtr + 1'b1;
                level <= level - 1'b1;
            end
            if (rdGnt) begin
                rdValid <= 1'b1;
            end else if (iRd_Ready) begin
                rdValid <= 1'b0;
            end
        end
    end

endmodule
